// File: rtl/load_use_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_use_stall_ctrl
// Purpose  : Load-use hazard unit for the ID stage. When an instruction in ID
//            reads the destination of a load sitting in EX, it holds PC and
//            IF/ID and injects ID/EX bubbles for LOAD_LAT cycles in total
//            (the detect cycle included). A branch/jump flush cancels any
//            stall. It also keeps a saturating count of stalled cycles.
//
// Parameters:
//   REG_AW   - register index width
//   LOAD_LAT - total stall cycles per hazard (>=1, 1 = single bubble)
//   CNT_W    - width of the stall-cycle counter
//
// Optional feature (macro HAZARD_MEM_WAIT_EN):
//   Adds the mem_ready input. If the load data has not returned when the
//   fixed stall window ends, the stall is extended until mem_ready=1.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   rs1_IF_ID      in   source reg 1 of instruction in ID
//   rs2_IF_ID      in   source reg 2 of instruction in ID
//   rs1_used       in   instruction in ID reads rs1
//   rs2_used       in   instruction in ID reads rs2
//   rd_ID_EX       in   destination reg of instruction in EX
//   mem_read_ID_EX in   instruction in EX is a load
//   flush          in   branch/jump flush, cancels any stall
//   mem_ready      in   load data returned (HAZARD_MEM_WAIT_EN only)
//   stall          out  hazard stall active (combinational)
//   pc_write_en    out  ~stall
//   if_id_write_en out  ~stall
//   id_ex_bubble   out  = stall, zero the ID/EX control signals
//   stall_cycles   out  saturating count of cycles with stall=1
//
// Revision : 1.0 - initial release
// ============================================================================
module load_use_stall_ctrl #(
    parameter int REG_AW   = 6,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_IF_ID,
    input  logic [REG_AW-1:0] rs2_IF_ID,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd_ID_EX,
    input  logic              mem_read_ID_EX,
    input  logic              flush,
`ifdef HAZARD_MEM_WAIT_EN
    input  logic              mem_ready,
`endif
    output logic              stall,
    output logic              pc_write_en,
    output logic              if_id_write_en,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int c_CNT_W = $clog2(LOAD_LAT) + 1;

    // Remaining STALL cycles after the one being entered; the detect cycle
    // and the first STALL cycle are both counted, hence LOAD_LAT-2.
    localparam int               c_CNT_INIT_I = (LOAD_LAT >= 2) ? (LOAD_LAT - 2) : 0;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(c_CNT_INIT_I);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_STALL    = 2'd1;
`ifdef HAZARD_MEM_WAIT_EN
    localparam logic [1:0] c_WAIT_MEM = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0]   r_stall_cycles;

    logic               w_hit;
    logic               w_stall;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_hit = mem_read_ID_EX && (rd_ID_EX != '0) &&
                   ((rs1_used && (rs1_IF_ID == rd_ID_EX)) ||
                    (rs2_used && (rs2_IF_ID == rd_ID_EX)));

    always_comb begin
        w_stall     = 1'b0;
        w_state_nxt = c_IDLE;
        w_cnt_nxt   = '0;
        // rst and flush both leave the defaults: no stall, back to IDLE.
        if (!rst && !flush) begin
            case (r_state)
                c_IDLE: begin
                    if (w_hit) begin
                        w_stall = 1'b1;
                        if (LOAD_LAT == 1) begin
`ifdef HAZARD_MEM_WAIT_EN
                            if (!mem_ready) begin
                                w_state_nxt = c_WAIT_MEM;
                            end
`endif
                        end else begin
                            w_state_nxt = c_STALL;
                            w_cnt_nxt   = c_CNT_INIT;
                        end
                    end
                end
                c_STALL: begin
                    // Inputs are ignored here; the hazard is re-evaluated
                    // only once back in IDLE.
                    w_stall = 1'b1;
                    if (r_cnt != '0) begin
                        w_state_nxt = c_STALL;
                        w_cnt_nxt   = r_cnt - c_CNT_W'(1);
                    end else begin
`ifdef HAZARD_MEM_WAIT_EN
                        if (!mem_ready) begin
                            w_state_nxt = c_WAIT_MEM;
                        end
`endif
                    end
                end
`ifdef HAZARD_MEM_WAIT_EN
                c_WAIT_MEM: begin
                    // Stall drops in the very cycle the data arrives.
                    if (!mem_ready) begin
                        w_stall     = 1'b1;
                        w_state_nxt = c_WAIT_MEM;
                    end
                end
`endif
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_cnt          <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign stall          = w_stall;
    assign pc_write_en    = ~w_stall;
    assign if_id_write_en = ~w_stall;
    assign id_ex_bubble   = w_stall;
    assign stall_cycles   = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_load_use_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_use_stall_ctrl
// Purpose  : Self-checking bench for load_use_stall_ctrl. Four instances
//            share one set of inputs: LOAD_LAT=1, LOAD_LAT=2, LOAD_LAT=3 and a
//            LOAD_LAT=2 copy with a 3-bit counter for saturation. A
//            cycle-by-cycle vector table covers the main behaviour; short
//            hand-written sequences cover saturation and the mem-wait option.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_use_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, mem_read, rs1_used, rs2_used, mem_ready;
    logic [5:0] rd, rs1, rs2;

    always #5 clk = ~clk;

    logic        stall1, pcw1, ifid1, bub1;
    logic [31:0] cyc1;
    logic        stall2, pcw2, ifid2, bub2;
    logic [31:0] cyc2;
    logic        stall3, pcw3, ifid3, bub3;
    logic [31:0] cyc3;
    logic        stalls, pcws, ifids, bubs;
    logic [2:0]  cycs;

    load_use_stall_ctrl #(.REG_AW(6), .LOAD_LAT(1), .CNT_W(32)) u_dut1 (
`ifdef HAZARD_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .clk(clk), .rst(rst), .rs1_IF_ID(rs1), .rs2_IF_ID(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ID_EX(rd),
        .mem_read_ID_EX(mem_read), .flush(flush), .stall(stall1),
        .pc_write_en(pcw1), .if_id_write_en(ifid1), .id_ex_bubble(bub1),
        .stall_cycles(cyc1));

    load_use_stall_ctrl #(.REG_AW(6), .LOAD_LAT(2), .CNT_W(32)) u_dut2 (
`ifdef HAZARD_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .clk(clk), .rst(rst), .rs1_IF_ID(rs1), .rs2_IF_ID(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ID_EX(rd),
        .mem_read_ID_EX(mem_read), .flush(flush), .stall(stall2),
        .pc_write_en(pcw2), .if_id_write_en(ifid2), .id_ex_bubble(bub2),
        .stall_cycles(cyc2));

    load_use_stall_ctrl #(.REG_AW(6), .LOAD_LAT(3), .CNT_W(32)) u_dut3 (
`ifdef HAZARD_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .clk(clk), .rst(rst), .rs1_IF_ID(rs1), .rs2_IF_ID(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ID_EX(rd),
        .mem_read_ID_EX(mem_read), .flush(flush), .stall(stall3),
        .pc_write_en(pcw3), .if_id_write_en(ifid3), .id_ex_bubble(bub3),
        .stall_cycles(cyc3));

    load_use_stall_ctrl #(.REG_AW(6), .LOAD_LAT(2), .CNT_W(3)) u_dut_sat (
`ifdef HAZARD_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .clk(clk), .rst(rst), .rs1_IF_ID(rs1), .rs2_IF_ID(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_ID_EX(rd),
        .mem_read_ID_EX(mem_read), .flush(flush), .stall(stalls),
        .pc_write_en(pcws), .if_id_write_en(ifids), .id_ex_bubble(bubs),
        .stall_cycles(cycs));

    typedef struct {
        logic       rst, flush, mr;
        logic [5:0] rd, rs1, rs2;
        logic       u1, u2;
        logic       s1, s2, s3;
        int         c2, c3;
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(int r, int f, int m, int d, int a, int b,
                                int u1, int u2, int s1, int s2, int s3,
                                int c2, int c3);
        vec_t v;
        v.rst = r[0];  v.flush = f[0]; v.mr = m[0];
        v.rd  = d[5:0]; v.rs1 = a[5:0]; v.rs2 = b[5:0];
        v.u1  = u1[0]; v.u2 = u2[0];
        v.s1  = s1[0]; v.s2 = s2[0]; v.s3 = s3[0];
        v.c2  = c2;    v.c3 = c3;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic m,
                         input logic [5:0] d, input logic [5:0] a,
                         input logic [5:0] b, input logic x1, input logic x2);
        rst = r; flush = f; mem_read = m; rd = d; rs1 = a; rs2 = b;
        rs1_used = x1; rs2_used = x2;
    endtask

    initial begin
        //          rst fl mr rd rs1 rs2 u1 u2  s1 s2 s3  c2 c3
        tbl[0]  = mk(1, 0, 1, 5, 5, 0, 1, 0,   0, 0, 0,  0, 0); // reset wins over hit
        tbl[1]  = mk(0, 0, 0, 1, 1, 0, 1, 0,   0, 0, 0,  0, 0); // not a load
        tbl[2]  = mk(0, 0, 0, 1, 1, 0, 1, 0,   0, 0, 0,  0, 0);
        tbl[3]  = mk(0, 0, 1, 5, 5, 0, 1, 0,   1, 1, 1,  0, 0); // rs1 hazard
        tbl[4]  = mk(0, 0, 0, 0, 5, 0, 1, 0,   0, 1, 1,  1, 1);
        tbl[5]  = mk(0, 0, 0, 0, 5, 0, 1, 0,   0, 0, 1,  2, 2);
        tbl[6]  = mk(0, 0, 0, 0, 5, 0, 1, 0,   0, 0, 0,  2, 3);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 1, 1,   0, 0, 0,  2, 3); // rd=0
        tbl[8]  = mk(0, 0, 1,10, 3,10, 1, 0,   0, 0, 0,  2, 3); // rs2 unused
        tbl[9]  = mk(0, 0, 1,10, 3,10, 1, 1,   1, 1, 1,  2, 3); // rs2 hazard
        tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0,  3, 4); // flush mid-stall
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  3, 4);
        tbl[12] = mk(0, 0, 1,10, 0,10, 0, 1,   1, 1, 1,  3, 4);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  4, 5); // reset mid-stall
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0);
        tbl[15] = mk(0, 0, 1,15,15, 0, 1, 0,   1, 1, 1,  0, 0); // back-to-back
        tbl[16] = mk(0, 0, 1,15,15, 0, 1, 0,   1, 1, 1,  1, 1);
        tbl[17] = mk(0, 0, 1,15,15, 0, 1, 0,   1, 1, 1,  2, 2);
        tbl[18] = mk(0, 0, 1,15,15, 0, 1, 0,   1, 1, 1,  3, 3);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1,  4, 4);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1,  4, 5);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  4, 6);
        tbl[22] = mk(0, 1, 1, 7, 7, 0, 1, 0,   0, 0, 0,  4, 6); // flush on detect
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,  4, 6);
        tbl[24] = mk(0, 0, 1, 7, 7, 0, 0, 0,   0, 0, 0,  4, 6); // rs1 unused

        mem_ready = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].flush, tbl[i].mr, tbl[i].rd,
                  tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2);
            #1;
            chk($sformatf("v%0d stall_lat1", i), stall1, tbl[i].s1);
            chk($sformatf("v%0d stall_lat2", i), stall2, tbl[i].s2);
            chk($sformatf("v%0d stall_lat3", i), stall3, tbl[i].s3);
            chk($sformatf("v%0d pc_write_en", i), pcw2, !tbl[i].s2);
            chk($sformatf("v%0d if_id_write_en", i), ifid2, !tbl[i].s2);
            chk($sformatf("v%0d id_ex_bubble", i), bub2, tbl[i].s2);
            chk($sformatf("v%0d cycles_lat2", i), cyc2, tbl[i].c2);
            chk($sformatf("v%0d cycles_lat3", i), cyc3, tbl[i].c3);
        end

        // Continuous hazard: LOAD_LAT=2 stalls every cycle; the 3-bit
        // counter copy must stop at 7 instead of wrapping.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(0, 0, 1, 9, 9, 0, 1, 0);
            #1;
            chk($sformatf("sat%0d stall_lat2", k), stall2, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat end stall_lat2", stall2, 0);
        chk("sat cycles_lat2", cyc2, 14);
        chk("sat cycles_cnt3", cycs, 7);

        repeat (3) @(negedge clk);

`ifdef HAZARD_MEM_WAIT_EN
        // Data returns late: 2 fixed cycles plus 3 waiting cycles, stall drops
        // in the mem_ready cycle.
        @(negedge clk);
        drive(0, 0, 1, 5, 5, 0, 1, 0);
        mem_ready = 1'b0;
        #1;
        chk("mw detect stall", stall2, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("mw hold%0d stall", k), stall2, 1);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("mw ready stall", stall2, 0);
        @(negedge clk);
        #1;
        chk("mw after stall", stall2, 0);
        chk("mw cycles_lat2", cyc2, 19);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
